// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter and sequencer sharing one 16x16 signed Booth multiplier among N clients.
// Each grant latches one operand pair, runs the multiplier load protocol, waits for done
// (bounded by a watchdog) and returns the product to the owner.
module booth_mul_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned IDXW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [16*N-1:0]   req_mcand,
  input  logic [16*N-1:0]   req_mplier,
  output logic [N-1:0]      gnt,
  output logic [N-1:0]      rsp_valid,
  output logic [31:0]       rsp_product,
  output logic              rsp_err,
  output logic              busy,
  output logic [IDXW-1:0]   owner,
  output logic              mul_rst,
  output logic              mul_start,
  output logic [15:0]       mul_data,
  input  logic              mul_done,
  input  logic [31:0]       mul_product
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StClr, StLdMc, StLdMp, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic            phase_q, phase_d;  // second cycle of the two-cycle CLR / LD_MC states
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [15:0]     mcand_q, mcand_d;
  logic [15:0]     mplier_q, mplier_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_product_q, rsp_product_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;
  logic            mul_rst_q, mul_rst_d;
  logic            mul_start_q, mul_start_d;
  logic [15:0]     mul_data_q, mul_data_d;

  logic            found;
  logic [IDXW-1:0] pick;
  logic [IDXW-1:0] cand;
  logic [IDXW:0]   cand_w;
  logic [15:0]     sel_mc, sel_mp;

  // Round-robin search: first set request at or above the pointer, wrapping modulo N.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    cand   = '0;
    cand_w = '0;
    for (int i = 0; i < int'(N); i++) begin
      cand_w = {1'b0, ptr_q} + (IDXW+1)'(i);
      if (cand_w >= (IDXW+1)'(N)) cand_w = cand_w - (IDXW+1)'(N);
      cand = cand_w[IDXW-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Operand mux for the selected requester.
  always_comb begin
    sel_mc = '0;
    sel_mp = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (pick == IDXW'(i)) begin
        sel_mc = req_mcand[16*i +: 16];
        sel_mp = req_mplier[16*i +: 16];
      end
    end
  end

  // Sequencer next state; outputs are decoded from the next state so they come out registered.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    rsp_product_d = rsp_product_q;
    rsp_err_d     = rsp_err_q;
    gnt_d         = '0;

    case (state_q)
      StIdle: begin
        if (found) begin
          state_d  = StClr;
          phase_d  = 1'b0;
          owner_d  = pick;
          mcand_d  = sel_mc;
          mplier_d = sel_mp;
          gnt_d    = N'(1) << pick;
          ptr_d    = (pick == IDXW'(N - 1)) ? '0 : pick + 1'b1;
        end
      end
      StClr: begin
        phase_d = ~phase_q;
        if (phase_q) state_d = StLdMc;
      end
      StLdMc: begin
        phase_d = ~phase_q;
        if (phase_q) state_d = StLdMp;
      end
      StLdMp: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // done has priority over a watchdog expiry in the same cycle
        if (mul_done) begin
          state_d       = StResp;
          rsp_product_d = mul_product;
          rsp_err_d     = 1'b0;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d       = StResp;
          rsp_product_d = '0;
          rsp_err_d     = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d      = (state_d != StIdle);
    mul_rst_d   = (state_d == StClr);
    mul_start_d = (state_d == StLdMc) || (state_d == StLdMp);
    rsp_valid_d = (state_d == StResp) ? (N'(1) << owner_d) : '0;
    case (state_d)
      StLdMc:                 mul_data_d = mcand_d;
      StLdMp, StWait, StResp: mul_data_d = mplier_d;
      default:                mul_data_d = '0;
    endcase
  end

  // State and output registers; reset also pulses mul_rst for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      phase_q       <= 1'b0;
      cnt_q         <= '0;
      ptr_q         <= '0;
      owner_q       <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_product_q <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      mul_rst_q     <= 1'b1;
      mul_start_q   <= 1'b0;
      mul_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      gnt_q         <= gnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_product_q <= rsp_product_d;
      rsp_err_q     <= rsp_err_d;
      busy_q        <= busy_d;
      mul_rst_q     <= mul_rst_d;
      mul_start_q   <= mul_start_d;
      mul_data_q    <= mul_data_d;
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_product = rsp_product_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign mul_rst     = mul_rst_q;
  assign mul_start   = mul_start_q;
  assign mul_data    = mul_data_q;

endmodule
